// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared FSM states, guard-bit count and counter sizing for the sequential square root
package sqrt_pkg;
  typedef enum logic [2:0] {IDLE, CALC, FIX, ROUND, DONE} sqrt_state_t;
  localparam int RES_EXTRA = 2;
  function automatic int cnt_width(input int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sqrt_nr_step.sv
// sqrt_nr_step: one combinational non-restoring square-root iteration
module sqrt_nr_step import sqrt_pkg::*; #(
  parameter int ROOT_LENGTH = 8
) (
  input  logic [ROOT_LENGTH+RES_EXTRA-1:0] r,
  input  logic [ROOT_LENGTH-1:0]           q,
  input  logic [1:0]                       bits,
  output logic [ROOT_LENGTH+RES_EXTRA-1:0] r_next,
  output logic [ROOT_LENGTH-1:0]           q_next
);
  logic [ROOT_LENGTH+RES_EXTRA-1:0] sh;
  assign sh     = {r[ROOT_LENGTH-1:0], bits};
  assign r_next = r[ROOT_LENGTH+RES_EXTRA-1] ? sh + {q, 2'b11} : sh - {q, 2'b01};
  assign q_next = {q[ROOT_LENGTH-2:0], ~r_next[ROOT_LENGTH+RES_EXTRA-1]};
endmodule

// File: rtl/sqrt_nr_seq.sv
// sqrt_nr_seq: sequential non-restoring integer square root with start/done handshake.
// Define SQRT_ROUND_EN to add a ROUND state and the rounded_up output (round to nearest).
module sqrt_nr_seq import sqrt_pkg::*; #(
  parameter int WORD_LENGTH = 16,
  localparam int ROOT_LENGTH = WORD_LENGTH / 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [WORD_LENGTH-1:0] DataInput,
  output logic                   ready,
  output logic                   busy,
  output logic                   done,
  output logic [ROOT_LENGTH-1:0] result,
`ifdef SQRT_ROUND_EN
  output logic [ROOT_LENGTH:0]   residue,
  output logic                   rounded_up
`else
  output logic [ROOT_LENGTH:0]   residue
`endif
);
  localparam int N  = ROOT_LENGTH;
  localparam int RW = N + RES_EXTRA;
  localparam int CW = cnt_width(N);
  if (WORD_LENGTH % 2 != 0 || WORD_LENGTH < 4) begin : g_bad_width
    $error("sqrt_nr_seq: WORD_LENGTH must be even and >= 4");
  end
  sqrt_state_t state, state_n;
  logic [WORD_LENGTH-1:0] op;
  logic [RW-1:0] r, r_step, r_fix;
  logic [N-1:0] q, q_step;
  logic [CW-1:0] cnt;
  sqrt_nr_step #(.ROOT_LENGTH(N)) u_step (
    .r, .q, .bits(op[WORD_LENGTH-1 -: 2]), .r_next(r_step), .q_next(q_step)
  );
  // a negative final remainder means the last trial subtraction overshot
  assign r_fix = r[RW-1] ? r + {1'b0, q, 1'b1} : r;
  assign ready = state == IDLE;
  assign done  = state == DONE;
  assign busy  = !ready && !done;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:  state_n = start ? CALC : IDLE;
      CALC:  state_n = cnt == '0 ? FIX : CALC;
`ifdef SQRT_ROUND_EN
      FIX:   state_n = ROUND;
      ROUND: state_n = DONE;
`else
      FIX:   state_n = DONE;
`endif
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op         <= '0;
      r          <= '0;
      q          <= '0;
      cnt        <= '0;
      result     <= '0;
      residue    <= '0;
`ifdef SQRT_ROUND_EN
      rounded_up <= 1'b0;
`endif
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        op  <= DataInput;
        r   <= '0;
        q   <= '0;
        cnt <= CW'(N - 1);
      end
      if (state == CALC) begin
        op  <= op << 2;
        r   <= r_step;
        q   <= q_step;
        cnt <= cnt - 1'b1;
      end
      if (state == FIX) begin
        result  <= q;
        residue <= r_fix[N:0];
`ifdef SQRT_ROUND_EN
        rounded_up <= 1'b0;
`endif
      end
`ifdef SQRT_ROUND_EN
      if (state == ROUND && residue > {1'b0, result}) begin
        result     <= result + 1'b1;
        rounded_up <= 1'b1;
      end
`endif
    end
  end
endmodule
